hazard_scoreboard: RTL and testbench

Parametrised hazard and bypass controller for the five-stage MIPS pipeline, driven by decoded Tuse/Tnew fields instead of raw opcodes. It keeps a registered shadow of the E/M/W destination records, plus a multiply/divide busy counter. From these it produces the F/D stall, the D/E flush, and forwarding selects for the D-, E- and M-stage operands. It sits beside the pipeline registers and replaces per-opcode stall and bypass decoding.

---
 rtl/hazard_scoreboard.sv | 140 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tuse/Tnew stall and bypass controller for the 5-stage pipeline (optional HAZARD_MD_EN md counter)
module hazard_scoreboard #(
    parameter int MD_MULT_CYCLES = 5,
    parameter int MD_DIV_CYCLES  = 10,
    parameter int MD_CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wr_addr,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_is_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic       flush_de,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt,
    output logic       md_busy
);

    logic [4:0] e_rs, e_rt, e_addr;
    logic [1:0] e_tnew;
    logic [4:0] m_rt, m_addr;
    logic [1:0] m_tnew;
    logic [4:0] w_addr;

    logic [1:0] d_tnew_c;
    logic       rs_stall, rt_stall, md_stall;

    assign d_tnew_c = (d_tnew == 2'd3) ? 2'd2 : d_tnew;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_addr <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_addr <= '0;
            m_tnew <= '0;
            w_addr <= '0;
        end else begin
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_addr <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_addr <= d_wr_addr;
                e_tnew <= d_tnew_c;
            end
            m_rt   <= e_rt;
            m_addr <= e_addr;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_addr <= m_addr;
        end
    end

    // Returns {stall, fwd}; the youngest matching stage decides alone.
    function automatic logic [2:0] d_resolve(input logic [4:0] r, input logic [1:0] tuse);
        logic [2:0] res;
        res = 3'b000;
        if (tuse != 2'd3 && r != 5'd0) begin
            if (r == e_addr) begin
                res[2]   = (e_tnew > tuse);
                res[1:0] = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
            end else if (r == m_addr) begin
                res[2]   = (m_tnew > tuse);
                res[1:0] = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
            end else if (r == w_addr) begin
                res[1:0] = 2'd3;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] e_resolve(input logic [4:0] r);
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (r == m_addr && m_tnew == 2'd0)
                sel = 2'd2;
            else if (r == w_addr)
                sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        logic [2:0] rs_res, rt_res;
        rs_res   = d_resolve(d_rs, d_tuse_rs);
        rt_res   = d_resolve(d_rt, d_tuse_rt);
        rs_stall = rs_res[2];
        rt_stall = rt_res[2];
        fwd_d_rs = rs_res[1:0];
        fwd_d_rt = rt_res[1:0];
        fwd_e_rs = e_resolve(e_rs);
        fwd_e_rt = e_resolve(e_rt);
        fwd_m_rt = (m_rt != 5'd0 && m_rt == w_addr) ? 2'd3 : 2'd0;
    end

`ifdef HAZARD_MD_EN
    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MD_MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(MD_DIV_CYCLES);

    logic [MD_CNT_W-1:0] md_cnt;

    // A start is itself an md use, so a reload can only happen once the counter has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            md_cnt <= '0;
        else if (d_md_start && !stall)
            md_cnt <= d_md_is_div ? DIV_LOAD : MULT_LOAD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = d_md_use & md_busy;
`else
    logic unused_md;
    assign unused_md = ^{d_md_start, d_md_is_div, d_md_use,
                         MD_MULT_CYCLES[0], MD_DIV_CYCLES[0], MD_CNT_W[0]};
    assign md_busy  = 1'b0;
    assign md_stall = 1'b0;
`endif

    assign stall    = rs_stall | rt_stall | md_stall;
    assign flush_de = stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_is_div, d_md_use;
    logic       stall, flush_de, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wr_addr  (d_wr_addr),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_is_div(d_md_is_div),
        .d_md_use   (d_md_use),
        .stall      (stall),
        .flush_de   (flush_de),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] wr, input logic [1:0] tn);
        d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
        d_wr_addr = wr; d_tnew = tn;
        d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;
        #1;
    endtask

    task automatic nop;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0);
    endtask

    task automatic drain;
        repeat (3) begin
            tick;
            nop;
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {3'b0, stall, flush_de, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy};
    endfunction

    initial begin
        reset = 1'b0;
        nop;
        for (int i = 0; i < 3; i++) begin
            d_rs = 5'($urandom); d_rt = 5'($urandom); d_wr_addr = 5'($urandom);
            d_tuse_rs = 2'($urandom); d_tuse_rt = 2'($urandom); d_tnew = 2'($urandom);
            d_md_start = 1'($urandom); d_md_is_div = 1'($urandom); d_md_use = 1'($urandom);
            #1;
            check("reset_outs", all_outs(), 16'h0);
            tick;
        end
        reset = 1'b1;
        set_d(5'd5, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0);
        check("post_reset_empty", all_outs(), 16'h0);
        drain;

        // load-use: lw $3 then addu $4,$3,$5
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd3, 2'd2);
        check("lw_no_stall", {15'd0, stall}, 16'd0);
        tick;
        set_d(5'd3, 5'd5, 2'd1, 2'd1, 5'd4, 2'd1);
        check("load_use_stall", {15'd0, stall}, 16'd1);
        check("flush_eq_stall", {15'd0, flush_de}, 16'd1);
        tick;
        check("load_use_release", {15'd0, stall}, 16'd0);
        check("load_use_fwd_d", {14'd0, fwd_d_rs}, 16'd0);
        tick;
        nop;
        check("load_use_fwd_e_rs", {14'd0, fwd_e_rs}, 16'd3);
        check("load_use_fwd_e_rt", {14'd0, fwd_e_rt}, 16'd0);
        drain;

        // ori $2 then beq $2,$0
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 2'd1);
        tick;
        set_d(5'd2, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        check("alu_beq_stall", {15'd0, stall}, 16'd1);
        tick;
        check("alu_beq_release", {15'd0, stall}, 16'd0);
        check("alu_beq_fwd_m", {14'd0, fwd_d_rs}, 16'd2);
        check("alu_beq_fwd_rt0", {14'd0, fwd_d_rt}, 16'd0);
        drain;

        // jal then beq $31
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0);
        tick;
        set_d(5'd31, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        check("jal_beq_stall", {15'd0, stall}, 16'd0);
        check("jal_beq_fwd_e", {14'd0, fwd_d_rs}, 16'd1);
        drain;

        // lw $7 then beq $7: two stall cycles, then W bypass
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd7, 2'd2);
        tick;
        set_d(5'd7, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
        check("lw_beq_stall1", {15'd0, stall}, 16'd1);
        tick;
        check("lw_beq_stall2", {15'd0, stall}, 16'd1);
        tick;
        check("lw_beq_release", {15'd0, stall}, 16'd0);
        check("lw_beq_fwd_w", {14'd0, fwd_d_rs}, 16'd3);
        drain;

        // lw $6 then sw $6,0($1)
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd6, 2'd2);
        tick;
        set_d(5'd1, 5'd6, 2'd1, 2'd2, 5'd0, 2'd0);
        check("lw_sw_no_stall", {15'd0, stall}, 16'd0);
        check("lw_sw_fwd_d_rt", {14'd0, fwd_d_rt}, 16'd0);
        tick;
        nop;
        check("lw_sw_fwd_e_rt", {14'd0, fwd_e_rt}, 16'd0);
        tick;
        check("lw_sw_fwd_m_rt", {14'd0, fwd_m_rt}, 16'd3);
        drain;

        // writes to $0 with readers of $0
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2);
        tick;
        set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            check("reg0_quiet", all_outs(), 16'h0);
            tick;
        end
        drain;

        // rs and rt both hazard on the same load
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd8, 2'd2);
        tick;
        set_d(5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 2'd0);
        check("dual_stall", {15'd0, stall}, 16'd1);
        check("dual_fwd", {12'd0, fwd_d_rs, fwd_d_rt}, 16'd0);
        drain;

        // tnew=3 must behave as 2
        set_d(5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 2'd3);
        tick;
        set_d(5'd9, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1);
        check("clamp_stall", {15'd0, stall}, 16'd1);
        tick;
        check("clamp_release", {15'd0, stall}, 16'd0);
        drain;

`ifdef HAZARD_MD_EN
        // div then mflo
        nop;
        d_md_start = 1'b1; d_md_is_div = 1'b1; d_md_use = 1'b1;
        #1;
        check("div_issue", {14'd0, stall, md_busy}, 16'd0);
        tick;
        d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b1;
        d_wr_addr = 5'd10; d_tnew = 2'd1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("div_busy_stall", {14'd0, stall, md_busy}, 16'd3);
            tick;
        end
        check("div_done", {14'd0, stall, md_busy}, 16'd0);
        drain;

        // reset mid countdown
        nop;
        d_md_start = 1'b1; d_md_is_div = 1'b1; d_md_use = 1'b1;
        #1;
        tick;
        nop;
        for (int i = 0; i < 3; i++) begin
            check("div_busy_pre_reset", {15'd0, md_busy}, 16'd1);
            tick;
        end
        reset = 1'b0;
        #1;
        check("md_reset_abort", {15'd0, md_busy}, 16'd0);
        tick;
        reset = 1'b1;
        drain;
`else
        nop;
        d_md_start = 1'b1; d_md_is_div = 1'b1; d_md_use = 1'b1;
        #1;
        tick;
        d_md_start = 1'b0; d_md_use = 1'b1;
        #1;
        check("md_disabled", {14'd0, stall, md_busy}, 16'd0);
        tick;
        check("md_disabled2", {14'd0, stall, md_busy}, 16'd0);
        drain;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
